len_range_sequencer: RTL

- Controller that splits an inclusive decimal range [lo, hi] into per-digit-length segments, clamping each segment to the min/max value of its length (10^(L-1) .. 10^L-1).
- Feeds the downstream per-length digit datapath (min/max length adjust and later enumeration stages) one segment at a time over a valid/ready handshake.
- Digit lengths are found sequentially, one power-of-ten compare per cycle.

---
 rtl/len_range_sequencer_if.sv | 28 ++
 rtl/len_range_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/len_range_sequencer_if.sv
// Handshake bundle between a range requester and the per-length segment sequencer.
interface len_range_sequencer_if #(
   parameter int unsigned W  = 32,
   parameter int unsigned LW = 4
);
   logic          start;
   logic [W-1:0]  lo;
   logic [W-1:0]  hi;
   logic          busy;
   logic          seg_valid;
   logic          seg_ready;
   logic [W-1:0]  seg_lo;
   logic [W-1:0]  seg_hi;
   logic [LW-1:0] seg_len;
   logic          seg_last;
   logic          done;
   logic          err;

   modport master (
      output start, lo, hi, seg_ready,
      input  busy, seg_valid, seg_lo, seg_hi, seg_len, seg_last, done, err
   );

   modport slave (
      input  start, lo, hi, seg_ready,
      output busy, seg_valid, seg_lo, seg_hi, seg_len, seg_last, done, err
   );
endinterface

// File: rtl/len_range_sequencer.sv
// Splits an inclusive decimal range [lo, hi] into segments of equal digit length,
// found by one power-of-ten compare per cycle, and streams them over valid/ready.
module len_range_sequencer #(
   parameter int unsigned W  = 32,
   parameter int unsigned LW = 4
) (
   input logic clk,
   input logic rst,
   len_range_sequencer_if.slave bus
);
   localparam int unsigned PW = 34;
   localparam logic [LW-1:0] MAXLEN = LW'(10);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] CHK  = 3'd1;
   localparam logic [2:0] LLO  = 3'd2;
   localparam logic [2:0] LHI  = 3'd3;
   localparam logic [2:0] EMIT = 3'd4;

   // 10^e at 34 bits so that 10^10 is representable
   function automatic logic [PW-1:0] pow10(input logic [LW-1:0] e);
      logic [PW-1:0] p;
      case (e)
         LW'(0):  p = 34'd1;
         LW'(1):  p = 34'd10;
         LW'(2):  p = 34'd100;
         LW'(3):  p = 34'd1000;
         LW'(4):  p = 34'd10000;
         LW'(5):  p = 34'd100000;
         LW'(6):  p = 34'd1000000;
         LW'(7):  p = 34'd10000000;
         LW'(8):  p = 34'd100000000;
         LW'(9):  p = 34'd1000000000;
         default: p = 34'd10000000000;
      endcase
      return p;
   endfunction

   logic [2:0]    state,    stateNxt;
   logic [W-1:0]  loQ,      loNxt;
   logic [W-1:0]  hiQ,      hiNxt;
   logic [LW-1:0] k,        kNxt;
   logic [LW-1:0] lenLo,    lenLoNxt;
   logic [LW-1:0] lenHi,    lenHiNxt;
   logic [LW-1:0] cur,      curNxt;
   logic          busyQ,    busyNxt;
   logic          segValid, segValidNxt;
   logic [W-1:0]  segLo,    segLoNxt;
   logic [W-1:0]  segHi,    segHiNxt;
   logic [LW-1:0] segLen,   segLenNxt;
   logic          segLast,  segLastNxt;
   logic          doneQ,    doneNxt;
   logic          errQ,     errNxt;
   logic [LW-1:0] nextCur;

   // Next-state and next-output logic
   always_comb begin
      stateNxt    = state;
      loNxt       = loQ;
      hiNxt       = hiQ;
      kNxt        = k;
      lenLoNxt    = lenLo;
      lenHiNxt    = lenHi;
      curNxt      = cur;
      busyNxt     = busyQ;
      segValidNxt = segValid;
      segLoNxt    = segLo;
      segHiNxt    = segHi;
      segLenNxt   = segLen;
      segLastNxt  = segLast;
      doneNxt     = 1'b0;
      errNxt      = errQ;
      nextCur     = cur + LW'(1);

      case (state)
         IDLE: begin
            if (bus.start) begin
               loNxt    = bus.lo;
               hiNxt    = bus.hi;
               errNxt   = 1'b0;
               busyNxt  = 1'b1;
               stateNxt = CHK;
            end
         end
         CHK: begin
            if (loQ > hiQ) begin
               errNxt   = 1'b1;
               doneNxt  = 1'b1;
               busyNxt  = 1'b0;
               stateNxt = IDLE;
            end else begin
               kNxt     = LW'(1);
               stateNxt = LLO;
            end
         end
         LLO: begin
            if ((PW'(loQ) >= pow10(k)) && (k < MAXLEN)) begin
               kNxt = k + LW'(1);
            end else begin
               lenLoNxt = k;
               stateNxt = LHI;
            end
         end
         LHI: begin
            // k already holds lenLo here, valid start point since hi >= lo
            if ((PW'(hiQ) >= pow10(k)) && (k < MAXLEN)) begin
               kNxt = k + LW'(1);
            end else begin
               lenHiNxt    = k;
               curNxt      = lenLo;
               segValidNxt = 1'b1;
               segLoNxt    = loQ;
               segHiNxt    = (lenLo == k) ? hiQ : W'(pow10(lenLo) - 34'd1);
               segLenNxt   = lenLo;
               segLastNxt  = (lenLo == k);
               stateNxt    = EMIT;
            end
         end
         EMIT: begin
            if (segValid && bus.seg_ready) begin
               if (segLast) begin
                  segValidNxt = 1'b0;
                  doneNxt     = 1'b1;
                  busyNxt     = 1'b0;
                  stateNxt    = IDLE;
               end else begin
                  curNxt     = nextCur;
                  segLoNxt   = W'(pow10(nextCur - LW'(1)));
                  segHiNxt   = (nextCur == lenHi) ? hiQ : W'(pow10(nextCur) - 34'd1);
                  segLenNxt  = nextCur;
                  segLastNxt = (nextCur == lenHi);
               end
            end
         end
         default: stateNxt = IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         loQ      <= '0;
         hiQ      <= '0;
         k        <= '0;
         lenLo    <= '0;
         lenHi    <= '0;
         cur      <= '0;
         busyQ    <= 1'b0;
         segValid <= 1'b0;
         segLo    <= '0;
         segHi    <= '0;
         segLen   <= '0;
         segLast  <= 1'b0;
         doneQ    <= 1'b0;
         errQ     <= 1'b0;
      end else begin
         state    <= stateNxt;
         loQ      <= loNxt;
         hiQ      <= hiNxt;
         k        <= kNxt;
         lenLo    <= lenLoNxt;
         lenHi    <= lenHiNxt;
         cur      <= curNxt;
         busyQ    <= busyNxt;
         segValid <= segValidNxt;
         segLo    <= segLoNxt;
         segHi    <= segHiNxt;
         segLen   <= segLenNxt;
         segLast  <= segLastNxt;
         doneQ    <= doneNxt;
         errQ     <= errNxt;
      end
   end

   assign bus.busy      = busyQ;
   assign bus.seg_valid = segValid;
   assign bus.seg_lo    = segLo;
   assign bus.seg_hi    = segHi;
   assign bus.seg_len   = segLen;
   assign bus.seg_last  = segLast;
   assign bus.done      = doneQ;
   assign bus.err       = errQ;
endmodule
